// File: rtl/branch_target_predictor_pkg.sv
// Shared encodings for the branch target predictor: prediction modes and
// 2-bit direction counter states.
package branch_target_predictor_pkg;

  // Prediction mode encodings (PREDICTOR_MODE parameter values)
  localparam logic [1:0] BP_NT    = 2'd0;  // always not taken
  localparam logic [1:0] BP_T     = 2'd1;  // always taken on BTB hit
  localparam logic [1:0] BP_SAT2  = 2'd2;  // 2-bit saturating counter
  localparam logic [1:0] BP_HYST2 = 2'd3;  // 2-bit hysteresis counter

  // Direction counter states; bit 1 is the predicted direction
  localparam logic [1:0] CNT_SNT = 2'b00;  // strong not taken
  localparam logic [1:0] CNT_WNT = 2'b01;  // weak not taken
  localparam logic [1:0] CNT_WT  = 2'b10;  // weak taken
  localparam logic [1:0] CNT_ST  = 2'b11;  // strong taken

  // True for modes whose counters are trained by resolved branches
  function automatic logic mode_trains_counter(input logic [1:0] mode);
    return (mode == BP_SAT2) || (mode == BP_HYST2);
  endfunction

endpackage

// File: rtl/branch_target_predictor_counter_next.sv
// Next-state logic for one 2-bit direction counter. Purely combinational;
// modes without a trained counter hold the current value.
module bp_counter_next
  import branch_target_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  input  logic [1:0] mode,
  output logic [1:0] cnt_next
);

  // Select the transition table for the active mode
  always_comb begin
    cnt_next = cnt;
    case (mode)
      BP_SAT2: begin
        if (taken) begin
          cnt_next = (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end else begin
          cnt_next = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
        end
      end
      BP_HYST2: begin
        // A weak state jumps straight to the strong state of the
        // observed direction; a strong state only weakens by one.
        if (taken) begin
          case (cnt)
            CNT_SNT: cnt_next = CNT_WNT;
            CNT_WNT: cnt_next = CNT_ST;
            CNT_WT:  cnt_next = CNT_ST;
            default: cnt_next = CNT_ST;
          endcase
        end else begin
          case (cnt)
            CNT_ST:  cnt_next = CNT_WT;
            CNT_WT:  cnt_next = CNT_SNT;
            CNT_WNT: cnt_next = CNT_SNT;
            default: cnt_next = CNT_SNT;
          endcase
        end
      end
      default: cnt_next = cnt;
    endcase
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry 2-bit direction counters.
// IF looks up pc_if combinationally; ID installs targets (update_tag); EX
// trains counters and statistics (update_bht). All writes land on the clock
// edge, so a same-cycle lookup sees the previous contents. There are no
// handshakes: every update input is a single-cycle strobe with no back-pressure.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int         WORD_SIZE      = 16,
  parameter int         BTB_IDX_SIZE   = 4,
  parameter logic [1:0] PREDICTOR_MODE = BP_SAT2,
  parameter logic [1:0] CNT_INIT       = 2'b01
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] pc_if,
  output logic                 tag_match,
  output logic [WORD_SIZE-1:0] branch_predicted_pc,
  input  logic                 update_tag,
  input  logic [WORD_SIZE-1:0] pc_for_btb_update,
  input  logic [WORD_SIZE-1:0] branch_target_for_btb_update,
  input  logic                 update_is_jump,
  input  logic                 update_bht,
  input  logic [WORD_SIZE-1:0] pc_real_update,
  input  logic                 branch_taken,
  input  logic                 branch_miss,
  input  logic                 stats_clear,
  output logic [WORD_SIZE-1:0] num_branch,
  output logic [WORD_SIZE-1:0] num_branch_miss
);

  localparam int DEPTH = 2 ** BTB_IDX_SIZE;
  localparam int TAG_W = WORD_SIZE - BTB_IDX_SIZE;
  localparam logic [WORD_SIZE-1:0] ONE      = {{(WORD_SIZE-1){1'b0}}, 1'b1};
  localparam logic [WORD_SIZE-1:0] ALL_ONES = {WORD_SIZE{1'b1}};
  localparam logic TRAINS = mode_trains_counter(PREDICTOR_MODE);

  // BTB storage, one element per index
  logic              valid_q   [DEPTH];
  logic [TAG_W-1:0]  tag_q     [DEPTH];
  logic [WORD_SIZE-1:0] target_q [DEPTH];
  logic              is_jump_q [DEPTH];
  logic [1:0]        cnt_q     [DEPTH];

  // Lookup path
  logic [BTB_IDX_SIZE-1:0] lk_idx;
  logic [TAG_W-1:0]        lk_tag;
  logic                    lk_hit;
  logic                    lk_dir;
  logic                    lk_take;

  // Install path (ID)
  logic [BTB_IDX_SIZE-1:0] upd_idx;
  logic [TAG_W-1:0]        upd_tag;

  // Training path (EX)
  logic [BTB_IDX_SIZE-1:0] bht_idx;
  logic [TAG_W-1:0]        bht_tag;
  logic                    bht_hit;
  logic                    bht_write;
  logic [1:0]              bht_cnt;
  logic [1:0]              bht_cnt_next;

  assign lk_idx  = pc_if[BTB_IDX_SIZE-1:0];
  assign lk_tag  = pc_if[WORD_SIZE-1:BTB_IDX_SIZE];
  assign upd_idx = pc_for_btb_update[BTB_IDX_SIZE-1:0];
  assign upd_tag = pc_for_btb_update[WORD_SIZE-1:BTB_IDX_SIZE];
  assign bht_idx = pc_real_update[BTB_IDX_SIZE-1:0];
  assign bht_tag = pc_real_update[WORD_SIZE-1:BTB_IDX_SIZE];

  // Mode-dependent predicted direction for the looked-up entry
  always_comb begin
    lk_dir = 1'b0;
    case (PREDICTOR_MODE)
      BP_NT:   lk_dir = 1'b0;
      BP_T:    lk_dir = 1'b1;
      default: lk_dir = cnt_q[lk_idx][1];
    endcase
  end

  // Hit detection and next-PC selection; reset forces a sequential fetch
  always_comb begin
    lk_hit  = reset_n && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_take = lk_hit && (is_jump_q[lk_idx] || lk_dir);
    tag_match = lk_hit;
    if (lk_take) begin
      branch_predicted_pc = target_q[lk_idx];
    end else begin
      branch_predicted_pc = pc_if + ONE;
    end
  end

  // Training qualifies only on a conditional entry owned by this PC; a
  // same-index install in the same cycle takes precedence.
  always_comb begin
    bht_cnt   = cnt_q[bht_idx];
    bht_hit   = valid_q[bht_idx] && (tag_q[bht_idx] == bht_tag) &&
                !is_jump_q[bht_idx];
    bht_write = TRAINS && update_bht && bht_hit &&
                !(update_tag && (upd_idx == bht_idx));
  end

  bp_counter_next u_counter_next (
    .cnt      (bht_cnt),
    .taken    (branch_taken),
    .mode     (PREDICTOR_MODE),
    .cnt_next (bht_cnt_next)
  );

  // BTB entry state: clear on reset, install from ID, train from EX
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= 1'b0;
        tag_q[i]     <= '0;
        target_q[i]  <= '0;
        is_jump_q[i] <= 1'b0;
        cnt_q[i]     <= CNT_INIT;
      end
    end else begin
      if (bht_write) begin
        cnt_q[bht_idx] <= bht_cnt_next;
      end
      if (update_tag) begin
        valid_q[upd_idx]   <= 1'b1;
        tag_q[upd_idx]     <= upd_tag;
        target_q[upd_idx]  <= branch_target_for_btb_update;
        is_jump_q[upd_idx] <= update_is_jump;
        cnt_q[upd_idx]     <= CNT_INIT;
      end
    end
  end

  // Saturating branch statistics, counted whether or not the BTB hit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_branch      <= '0;
      num_branch_miss <= '0;
    end else if (stats_clear) begin
      num_branch      <= '0;
      num_branch_miss <= '0;
    end else if (update_bht) begin
      if (num_branch != ALL_ONES) begin
        num_branch <= num_branch + ONE;
      end
      if (branch_miss && (num_branch_miss != ALL_ONES)) begin
        num_branch_miss <= num_branch_miss + ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: four 16-bit instances (one per mode)
// plus an 8-bit mode-2 instance for quick statistics saturation, all driven
// by shared inputs and checked against a table-level model every cycle.
module tb_branch_target_predictor;

  localparam int NI = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [15:0] pc_if, pc_upd, tgt_upd, pc_real;
  logic update_tag, update_is_jump, update_bht;
  logic branch_taken, branch_miss, stats_clear;

  logic        tm   [NI];
  logic [15:0] pred [NI];
  logic [15:0] nb   [NI];
  logic [15:0] nm   [NI];
  logic [7:0]  pred8, nb8, nm8;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    branch_target_predictor #(
      .WORD_SIZE(16), .BTB_IDX_SIZE(4), .PREDICTOR_MODE(2'(g)), .CNT_INIT(2'b01)
    ) dut (
      .clk(clk), .reset_n(reset_n), .pc_if(pc_if),
      .tag_match(tm[g]), .branch_predicted_pc(pred[g]),
      .update_tag(update_tag), .pc_for_btb_update(pc_upd),
      .branch_target_for_btb_update(tgt_upd), .update_is_jump(update_is_jump),
      .update_bht(update_bht), .pc_real_update(pc_real),
      .branch_taken(branch_taken), .branch_miss(branch_miss),
      .stats_clear(stats_clear),
      .num_branch(nb[g]), .num_branch_miss(nm[g])
    );
  end

  branch_target_predictor #(
    .WORD_SIZE(8), .BTB_IDX_SIZE(4), .PREDICTOR_MODE(2'd2), .CNT_INIT(2'b01)
  ) dut8 (
    .clk(clk), .reset_n(reset_n), .pc_if(pc_if[7:0]),
    .tag_match(tm[4]), .branch_predicted_pc(pred8),
    .update_tag(update_tag), .pc_for_btb_update(pc_upd[7:0]),
    .branch_target_for_btb_update(tgt_upd[7:0]), .update_is_jump(update_is_jump),
    .update_bht(update_bht), .pc_real_update(pc_real[7:0]),
    .branch_taken(branch_taken), .branch_miss(branch_miss),
    .stats_clear(stats_clear),
    .num_branch(nb8), .num_branch_miss(nm8)
  );
  assign pred[4] = {8'h00, pred8};
  assign nb[4]   = {8'h00, nb8};
  assign nm[4]   = {8'h00, nm8};

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input int k,
                       input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d got=%h expected=%h t=%0t", name, k, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [NI][16];
  int          m_tag   [NI][16];
  logic [15:0] m_tgt   [NI][16];
  bit          m_jmp   [NI][16];
  int          m_cnt   [NI][16];
  int          m_nb    [NI];
  int          m_nm    [NI];

  function automatic int inst_mode(input int k);
    return (k == 4) ? 2 : k;
  endfunction

  function automatic int inst_mask(input int k);
    return (k == 4) ? 32'hFF : 32'hFFFF;
  endfunction

  function automatic int next_cnt(input int mode, input int c, input bit t);
    if (mode == 2) return t ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
    if (mode == 3) return t ? ((c == 0) ? 1 : 3) : ((c == 3) ? 2 : 0);
    return c;
  endfunction

  // Model state advances with the DUT; reset clears it at once
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NI; k++) begin
        m_nb[k] = 0;
        m_nm[k] = 0;
        for (int e = 0; e < 16; e++) begin
          m_valid[k][e] = 0; m_tag[k][e] = 0; m_tgt[k][e] = '0;
          m_jmp[k][e] = 0;   m_cnt[k][e] = 1;
        end
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        int msk, ui, bi, ut, bt, mode;
        bit train;
        msk  = inst_mask(k);
        mode = inst_mode(k);
        ui = int'(pc_upd) & 15;   ut = (int'(pc_upd) & msk) / 16;
        bi = int'(pc_real) & 15;  bt = (int'(pc_real) & msk) / 16;
        train = update_bht && m_valid[k][bi] && m_tag[k][bi] == bt && !m_jmp[k][bi];
        if (train) m_cnt[k][bi] = next_cnt(mode, m_cnt[k][bi], branch_taken);
        if (update_tag) begin
          m_valid[k][ui] = 1; m_tag[k][ui] = ut;
          m_tgt[k][ui] = tgt_upd & 16'(msk);
          m_jmp[k][ui] = update_is_jump; m_cnt[k][ui] = 1;
        end
        if (stats_clear) begin
          m_nb[k] = 0; m_nm[k] = 0;
        end else if (update_bht) begin
          if (m_nb[k] < msk) m_nb[k]++;
          if (branch_miss && m_nm[k] < msk) m_nm[k]++;
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        int msk, p, idx, mode;
        bit hit, dir, take;
        logic [15:0] ep;
        msk  = inst_mask(k);
        mode = inst_mode(k);
        p    = int'(pc_if) & msk;
        idx  = p & 15;
        hit  = reset_n && m_valid[k][idx] && m_tag[k][idx] == p / 16;
        dir  = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (m_cnt[k][idx] >= 2);
        take = hit && (m_jmp[k][idx] || dir);
        ep   = take ? m_tgt[k][idx] : 16'((p + 1) & msk);
        check("model_tag_match", k, {15'd0, tm[k]}, {15'd0, hit});
        check("model_pred_pc", k, pred[k], ep);
        check("model_num_branch", k, nb[k], 16'(m_nb[k]));
        check("model_num_miss", k, nm[k], 16'(m_nm[k]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    update_tag  = 1'b0;
    update_bht  = 1'b0;
    stats_clear = 1'b0;
  endtask

  task automatic install(input logic [15:0] pc, input logic [15:0] tgt, input bit jmp);
    update_tag = 1'b1; pc_upd = pc; tgt_upd = tgt; update_is_jump = jmp;
    cycle();
  endtask

  task automatic train(input logic [15:0] pc, input bit taken, input bit miss);
    update_bht = 1'b1; pc_real = pc; branch_taken = taken; branch_miss = miss;
    cycle();
  endtask

  task automatic look(input logic [15:0] pc);
    pc_if = pc;
    @(negedge clk);
  endtask

  task automatic expect_pred(input int k, input bit exp_tm, input logic [15:0] exp_pc);
    check("lit_tag_match", k, {15'd0, tm[k]}, {15'd0, exp_tm});
    check("lit_pred_pc", k, pred[k], exp_pc);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset_n = 1'b0;
    pc_if = 16'h0010; pc_upd = '0; tgt_upd = '0; pc_real = '0;
    update_tag = 0; update_is_jump = 0; update_bht = 0;
    branch_taken = 0; branch_miss = 0; stats_clear = 0;

    // Reset state: sequential prediction while reset is held
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      expect_pred(k, 1'b0, 16'h0011);
      check("lit_reset_nb", k, nb[k], 16'h0000);
    end
    chk_en = 1'b1;
    @(posedge clk); #1; reset_n = 1'b1;

    look(16'h0010);
    for (int k = 0; k < 4; k++) expect_pred(k, 1'b0, 16'h0011);
    look(16'hFFFF);
    for (int k = 0; k < 4; k++) expect_pred(k, 1'b0, 16'h0000);

    // Unconditional jump predicts its target in every mode
    install(16'h0010, 16'h0040, 1'b1);
    look(16'h0010);
    for (int k = 0; k < 4; k++) expect_pred(k, 1'b1, 16'h0040);

    // Conditional entry starts weak-not-taken
    install(16'h0012, 16'h0030, 1'b0);
    look(16'h0012);
    expect_pred(0, 1'b1, 16'h0013);
    expect_pred(1, 1'b1, 16'h0030);
    expect_pred(2, 1'b1, 16'h0013);
    expect_pred(3, 1'b1, 16'h0013);

    repeat (3) train(16'h0012, 1'b1, 1'b0);
    look(16'h0012);
    expect_pred(2, 1'b1, 16'h0030);
    expect_pred(3, 1'b1, 16'h0030);
    train(16'h0012, 1'b0, 1'b0);
    look(16'h0012);
    expect_pred(2, 1'b1, 16'h0030);
    expect_pred(3, 1'b1, 16'h0030);
    train(16'h0012, 1'b0, 1'b0);
    look(16'h0012);
    expect_pred(2, 1'b1, 16'h0013);
    expect_pred(3, 1'b1, 16'h0013);
    // Mode 2 sits at 01, mode 3 at 00: one taken separates them
    train(16'h0012, 1'b1, 1'b0);
    look(16'h0012);
    expect_pred(2, 1'b1, 16'h0030);
    expect_pred(3, 1'b1, 16'h0013);

    // Mode 3 from a fresh 01: taken -> 11, not taken -> 10, again -> 00
    install(16'h0013, 16'h0077, 1'b0);
    train(16'h0013, 1'b1, 1'b0);
    look(16'h0013); expect_pred(3, 1'b1, 16'h0077);
    train(16'h0013, 1'b0, 1'b0);
    look(16'h0013); expect_pred(3, 1'b1, 16'h0077);
    train(16'h0013, 1'b0, 1'b0);
    look(16'h0013); expect_pred(3, 1'b1, 16'h0014);

    // Aliasing: 0x0022 evicts 0x0012
    install(16'h0022, 16'h0050, 1'b0);
    look(16'h0012);
    for (int k = 0; k < 4; k++) expect_pred(k, 1'b0, 16'h0013);
    look(16'h0022);
    expect_pred(1, 1'b1, 16'h0050);
    expect_pred(2, 1'b1, 16'h0023);
    train(16'h0012, 1'b1, 1'b0);
    look(16'h0022); expect_pred(2, 1'b1, 16'h0023);
    train(16'h0022, 1'b1, 1'b0);
    look(16'h0022); expect_pred(2, 1'b1, 16'h0050);
    // Same-cycle install and train at one index: install wins, cnt = 01
    update_tag = 1'b1; pc_upd = 16'h0022; tgt_upd = 16'h0060; update_is_jump = 1'b0;
    update_bht = 1'b1; pc_real = 16'h0022; branch_taken = 1'b1;
    cycle();
    look(16'h0022);
    expect_pred(1, 1'b1, 16'h0060);
    expect_pred(2, 1'b1, 16'h0023);
    expect_pred(3, 1'b1, 16'h0023);

    // Statistics: 5 resolved branches, 2 of them mispredicted
    stats_clear = 1'b1; cycle();
    for (int i = 0; i < 5; i++) train(16'h0100 + 16'(i), 1'b0, (i == 1 || i == 3));
    @(negedge clk);
    check("lit_num_branch", 2, nb[2], 16'd5);
    check("lit_num_miss", 2, nm[2], 16'd2);
    stats_clear = 1'b1; update_bht = 1'b1; branch_miss = 1'b1; cycle();
    @(negedge clk);
    check("lit_clear_nb", 2, nb[2], 16'd0);
    check("lit_clear_nm", 2, nm[2], 16'd0);
    for (int i = 0; i < 260; i++) train(16'h0055, 1'($urandom_range(0, 1)), 1'b1);
    @(negedge clk);
    check("lit_sat_nb8", 4, nb[4], 16'h00FF);
    check("lit_sat_nm8", 4, nm[4], 16'h00FF);
    check("lit_nb16", 2, nb[2], 16'd260);

    // Randomized traffic over a small PC window so entries hit and alias
    for (int i = 0; i < 3000; i++) begin
      pc_if = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) pc_if = 16'($urandom);
      update_tag = ($urandom_range(0, 3) == 0);
      pc_upd = 16'($urandom_range(0, 63));
      tgt_upd = 16'($urandom);
      update_is_jump = ($urandom_range(0, 4) == 0);
      update_bht = ($urandom_range(0, 1) == 1);
      pc_real = 16'($urandom_range(0, 63));
      branch_taken = 1'($urandom_range(0, 1));
      branch_miss = 1'($urandom_range(0, 1));
      stats_clear = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    update_tag = 0; update_bht = 0; stats_clear = 0;

    // Mid-stream reset clears BTB and statistics in the same cycle
    install(16'h0010, 16'h0040, 1'b1);
    train(16'h0200, 1'b0, 1'b1);
    look(16'h0010);
    expect_pred(2, 1'b1, 16'h0040);
    @(posedge clk); #1; reset_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      expect_pred(k, 1'b0, 16'h0011);
      check("lit_rst_nb", k, nb[k], 16'h0000);
      check("lit_rst_nm", k, nm[k], 16'h0000);
    end
    @(posedge clk); #1; reset_n = 1'b1;
    look(16'h0010);
    for (int k = 0; k < 4; k++) expect_pred(k, 1'b0, 16'h0011);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
Parametrised next-generation branch predictor for the 16-bit pipelined CPU: direct-mapped BTB plus per-entry pattern counters, with a selectable prediction mode. IF looks up the fetched PC combinationally and gets a predicted next PC. ID installs targets for jumps and I-type branches. EX updates the direction counters and the hardware branch/miss statistics.

Parameters:
WORD_SIZE, 16, width of PC, target and statistics counters
BTB_IDX_SIZE, 4, index bits; BTB depth = 2**BTB_IDX_SIZE; tag = PC[WORD_SIZE-1:BTB_IDX_SIZE]
PREDICTOR_MODE, 2, 0 = always-not-taken, 1 = always-taken-on-hit, 2 = 2-bit saturating, 3 = 2-bit hysteresis
CNT_INIT, 2'b01, counter value written at reset and on every tag install

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
pc_if  input  WORD_SIZE  PC just fetched
tag_match  output  1  valid entry at index(pc_if) with equal tag
branch_predicted_pc  output  WORD_SIZE  predicted next PC
update_tag  input  1  install entry (ID stage)
pc_for_btb_update  input  WORD_SIZE  PC of the decoded branch/jump
branch_target_for_btb_update  input  WORD_SIZE  its target
update_is_jump  input  1  entry is unconditional
update_bht  input  1  resolved conditional branch (EX stage)
pc_real_update  input  WORD_SIZE  PC of the resolved branch
branch_taken  input  1  actual direction
branch_miss  input  1  prediction was wrong
stats_clear  input  1  synchronous clear of statistics
num_branch  output  WORD_SIZE  resolved conditional branches
num_branch_miss  output  WORD_SIZE  mispredicted ones

Behaviour:
- Entry fields: valid, tag, target, is_jump, cnt[1:0].
- Reset (asynchronous, while reset_n = 0): all entries valid = 0, cnt = CNT_INIT, tag/target = 0; num_branch = num_branch_miss = 0.
- Lookup is combinational with zero latency:
  - hit = tag_match.
  - take = hit & (is_jump | mode-dependent direction). Mode 0: 0. Mode 1: 1. Modes 2/3: cnt[1].
  - branch_predicted_pc = take ? target : pc_if + 1 (wraps modulo 2**WORD_SIZE).
  - During reset: tag_match = 0 and branch_predicted_pc = pc_if + 1.
- Writes take effect on the clock edge. A lookup in the same cycle sees the old contents (no bypass).
- update_tag: sets valid = 1 and writes tag, target and is_jump at index(pc_for_btb_update). cnt is reset to CNT_INIT, including on overwrite of an aliasing entry.
- update_bht: acts only if the entry at index(pc_real_update) is valid, tag-equal and not is_jump; otherwise the counter is unchanged.
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- Mode 2 (saturating): taken → +1, saturating at 11; not taken → −1, saturating at 00.
- Mode 3 (hysteresis):
  - taken: 00→01, 01→11, 10→11, 11→11.
  - not taken: 11→10, 10→00, 01→00, 00→00.
- Modes 0/1: counters are never written.
- Same-cycle update_tag and update_bht at the same index: the tag install wins, and the counter becomes CNT_INIT. At different indices, both apply.
- Statistics (counted regardless of hit):
  - Every update_bht increments num_branch; update_bht & branch_miss also increments num_branch_miss.
  - Both counters saturate at all-ones.
  - stats_clear takes priority over increments in the same cycle.
- Reset asserted mid-operation clears everything immediately. The first post-reset lookup is a miss.

Decomposition:
- Shared constants file holds the PREDICTOR_MODE encodings (BP_NT, BP_T, BP_SAT2, BP_HYST2) and the counter state encodings. It is `include`d like the existing constants and opcodes files.
- One natural sub-module: bp_counter_next. It is combinational: inputs cnt, taken, mode; output next cnt. It is instantiated once for the update path.

Test Plan:
- Reset, then pc_if = 0x0010 → tag_match = 0, branch_predicted_pc = 0x0011. Also pc_if = 0xFFFF → 0x0000 (wrap).
- update_tag at 0x0010 with target 0x0040 and is_jump = 1. On the next cycle pc_if = 0x0010 → tag_match = 1, branch_predicted_pc = 0x0040 in all four modes except mode 0, where is_jump still gives 0x0040.
- Mode 2: install conditional 0x0012 → 0x0030 (cnt = 01), predict 0x0013. Apply taken, taken, taken → predict 0x0030 and cnt = 11. Apply not-taken once → still 0x0030. Apply it again → 0x0013.
- Mode 3: from cnt = 01, one taken → cnt = 11. Then one not-taken → 10, and a second not-taken → 00.
- Alias test with BTB_IDX_SIZE = 4: install 0x0012, then install 0x0022 → lookup of 0x0012 misses. update_bht for 0x0012 leaves the 0x0022 counter unchanged. Also check same-cycle tag+bht at one index → cnt = 01.
- Statistics: 5 update_bht pulses with 2 misses → num_branch = 5, num_branch_miss = 2. Preload near 0xFFFF to confirm saturation. stats_clear together with update_bht → 0. Assert reset_n low mid-stream → counters 0 and BTB empty on the same cycle.
